// File: rtl/cic_up_s3_pkg.sv
// Shared definitions for the 3-stage CIC interpolator: phase counter width,
// stage mode selector and the phase-counter wrap helper.
package cic_up_s3_pkg;

  localparam int CIC_CNT_W = 16;

  typedef enum logic {
    STAGE_COMB  = 1'b0,
    STAGE_INTEG = 1'b1
  } stage_mode_e;

  function automatic logic [CIC_CNT_W-1:0] next_count(
    input logic [CIC_CNT_W-1:0] cur,
    input logic [CIC_CNT_W-1:0] last
  );
    logic [CIC_CNT_W-1:0] nxt;
    if (cur == last) begin
      nxt = {CIC_CNT_W{1'b0}};
    end else begin
      nxt = cur + {{(CIC_CNT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cic_up_s3_stage.sv
// One CIC section: a delay register with its own enable plus an adder (integrator)
// or subtractor (comb). All arithmetic wraps modulo 2^W.
module cic_stage
  import cic_up_s3_pkg::*;
#(
  parameter int          W    = 19,
  parameter stage_mode_e MODE = STAGE_COMB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly;
  logic [W-1:0] dly_next;

  // comb: out = in - delayed in; integrator: out is the running sum register
  always_comb begin
    dly_next = din;
    dout     = din - dly;
    if (MODE == STAGE_INTEG) begin
      dly_next = dly + din;
      dout     = dly;
    end else begin
      dly_next = din;
      dout     = din - dly;
    end
  end

  // delay / accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly <= {W{1'b0}};
    end else if (en) begin
      dly <= dly_next;
    end
  end

endmodule

// File: rtl/cic_up_s3.sv
// 3-stage CIC interpolator: low-rate combs, zero-stuffing by FACTOR, high-rate
// integrators, registered output with a registered enable marker.
module cic_up_s3
  import cic_up_s3_pkg::*;
#(
  parameter int FACTOR       = 10,
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic [INPUT_WIDTH-1:0]  filter_in,
  output logic                    in_strobe,
  output logic [OUTPUT_WIDTH-1:0] filter_out,
  output logic                    ce_out
);

  localparam logic [CIC_CNT_W-1:0] LAST_COUNT = CIC_CNT_W'(FACTOR - 1);
  localparam logic [CIC_CNT_W-1:0] ONE_COUNT  = CIC_CNT_W'(1);

  logic [CIC_CNT_W-1:0]    cur_count;
  logic                    phase_0;
  logic                    phase_1;
  logic [INPUT_WIDTH-1:0]  in_reg;
  logic [OUTPUT_WIDTH-1:0] in_ext;
  logic [OUTPUT_WIDTH-1:0] zero_stuff;
  logic [OUTPUT_WIDTH-1:0] comb_data  [0:3];
  logic [OUTPUT_WIDTH-1:0] integ_data [0:3];

  assign phase_0   = clk_enable && (cur_count == {CIC_CNT_W{1'b0}});
  assign phase_1   = clk_enable && (cur_count == ONE_COUNT);
  assign in_strobe = phase_0;
  assign in_ext    = {{(OUTPUT_WIDTH-INPUT_WIDTH){in_reg[INPUT_WIDTH-1]}}, in_reg};

  // phase counter and input capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_count <= {CIC_CNT_W{1'b0}};
      in_reg    <= {INPUT_WIDTH{1'b0}};
    end else if (clk_enable) begin
      cur_count <= next_count(cur_count, LAST_COUNT);
      if (phase_0) begin
        in_reg <= filter_in;
      end
    end
  end

  // combs see the freshly captured sample during count 1 and latch it on that edge
  assign comb_data[0] = in_ext;
  for (genvar k = 0; k < 3; k++) begin : g_comb
    cic_stage #(.W(OUTPUT_WIDTH), .MODE(STAGE_COMB)) u_comb (
      .clk   (clk),
      .reset (reset),
      .en    (phase_1),
      .din   (comb_data[k]),
      .dout  (comb_data[k+1])
    );
  end

  // zero-stuffing: one comb result per FACTOR high-rate cycles
  always_comb begin
    zero_stuff = {OUTPUT_WIDTH{1'b0}};
    if (cur_count == ONE_COUNT) begin
      zero_stuff = comb_data[3];
    end else begin
      zero_stuff = {OUTPUT_WIDTH{1'b0}};
    end
  end

  assign integ_data[0] = zero_stuff;
  for (genvar k = 0; k < 3; k++) begin : g_integ
    cic_stage #(.W(OUTPUT_WIDTH), .MODE(STAGE_INTEG)) u_integ (
      .clk   (clk),
      .reset (reset),
      .en    (clk_enable),
      .din   (integ_data[k]),
      .dout  (integ_data[k+1])
    );
  end

  // output register and enable marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_out <= {OUTPUT_WIDTH{1'b0}};
      ce_out     <= 1'b0;
    end else begin
      ce_out <= clk_enable;
      if (clk_enable) begin
        filter_out <= integ_data[3];
      end
    end
  end

endmodule

// File: tb/tb_cic_up_s3.sv
// Scoreboard bench for cic_up_s3: expected outputs come from a direct FIR model
// of the cascaded boxcars applied to the zero-stuffed input.
`timescale 1ns/1ps
module tb_cic_up_s3;

  localparam int R = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        clk_enable = 1'b0, clk_enable2 = 1'b0, clk_enable3 = 1'b0;
  logic [11:0] filter_in = 12'd0, filter_in2 = 12'd0, filter_in3 = 12'd0;
  logic        in_strobe, in_strobe2, in_strobe3;
  logic        ce_out, ce_out2, ce_out3;
  logic [18:0] filter_out;
  logic [13:0] filter_out2;
  logic [14:0] filter_out3;

  cic_up_s3 #(.FACTOR(10), .INPUT_WIDTH(12), .OUTPUT_WIDTH(19)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
    .in_strobe(in_strobe), .filter_out(filter_out), .ce_out(ce_out));

  cic_up_s3 #(.FACTOR(2), .INPUT_WIDTH(12), .OUTPUT_WIDTH(14)) dut_r2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable2), .filter_in(filter_in2),
    .in_strobe(in_strobe2), .filter_out(filter_out2), .ce_out(ce_out2));

  cic_up_s3 #(.FACTOR(2), .INPUT_WIDTH(12), .OUTPUT_WIDTH(15)) dut_w15 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable3), .filter_in(filter_in3),
    .in_strobe(in_strobe3), .filter_out(filter_out3), .ce_out(ce_out3));

  int errors = 0;
  int checks = 0;

  longint imp_tbl [29] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 63, 69, 73, 75, 75,
                           73, 69, 63, 55, 45, 36, 28, 21, 15, 10, 6, 3, 1, 0};

  // model state for the FACTOR=10 instance
  int     m_count;
  int     xup[$];
  longint exp_q[$];
  longint last_out;
  logic   last_ce;
  int     en_idx;
  int     last_strobe;
  bit     have_strobe;
  longint got[$];

  function automatic int h_coef(int r, int k);
    int c = 0;
    for (int a = 0; a < r; a++)
      for (int b = 0; b < r; b++)
        if ((k - a - b >= 0) && (k - a - b < r)) c++;
    return c;
  endfunction

  function automatic longint wrap(longint v, int w);
    longint m = longint'(1) << w;
    longint u = v & (m - 1);
    if (u >= (m >> 1)) u = u - m;
    return u;
  endfunction

  function automatic longint y_main();
    longint s = 0;
    int n = xup.size() - 1;
    for (int k = 0; k <= 3 * (R - 1); k++)
      if (n - k >= 0) s += longint'(h_coef(R, k)) * longint'(xup[n - k]);
    return wrap(s, 19);
  endfunction

  task automatic main_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (filter_out !== 19'd0) begin
      errors++; $display("FAIL reset_out: got %0d expected 0", $signed(filter_out));
    end
    checks++;
    if (ce_out !== 1'b0) begin
      errors++; $display("FAIL reset_ce: got %b expected 0", ce_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = 0; xup.delete(); exp_q = '{0, 0, 0, 0};
    last_out = 0; last_ce = 1'b0; en_idx = 0; have_strobe = 1'b0;
  endtask

  task automatic main_cycle(input logic en, input logic signed [11:0] x);
    logic exp_strobe;
    clk_enable = en;
    filter_in  = x;
    #1;
    exp_strobe = en && (m_count == 0);
    checks++;
    if (in_strobe !== exp_strobe) begin
      errors++; $display("FAIL in_strobe: got %b expected %b (phase %0d)", in_strobe, exp_strobe, m_count);
    end
    if (in_strobe === 1'b1) begin
      if (have_strobe) begin
        checks++;
        if (en_idx - last_strobe != R) begin
          errors++; $display("FAIL strobe_period: got %0d expected %0d", en_idx - last_strobe, R);
        end
      end
      have_strobe = 1'b1;
      last_strobe = en_idx;
    end
    @(posedge clk); #1;
    if (en) begin
      xup.push_back((m_count == 0) ? int'(x) : 0);
      m_count = (m_count == R - 1) ? 0 : m_count + 1;
      en_idx++;
      exp_q.push_back(y_main());
      last_out = exp_q.pop_front();
      got.push_back(longint'($signed(filter_out)));
    end
    last_ce = en;
    checks++;
    if (longint'($signed(filter_out)) !== last_out) begin
      errors++; $display("FAIL filter_out: got %0d expected %0d", $signed(filter_out), last_out);
    end
    checks++;
    if (ce_out !== last_ce) begin
      errors++; $display("FAIL ce_out: got %b expected %b", ce_out, last_ce);
    end
  endtask

  task automatic test_reset();
    clk_enable = 1'b1;
    main_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (in_strobe !== 1'b1) begin
      errors++; $display("FAIL reset_strobe_en: got %b expected 1", in_strobe);
    end
    clk_enable = 1'b0;
    #1;
    checks++;
    if (in_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_strobe_dis: got %b expected 0", in_strobe);
    end
    main_reset();
  endtask

  task automatic check_impulse_table(input string name);
    longint sum = 0;
    checks++;
    if (got.size() < 33) begin
      errors++; $display("FAIL %s_len: got %0d values expected at least 33", name, got.size());
    end else begin
      for (int k = 0; k < 29; k++) begin
        checks++;
        if (got[k + 4] !== imp_tbl[k]) begin
          errors++; $display("FAIL %s[%0d]: got %0d expected %0d", name, k, got[k + 4], imp_tbl[k]);
        end
        sum += got[k + 4];
      end
      checks++;
      if (sum !== 1000) begin
        errors++; $display("FAIL %s_sum: got %0d expected 1000", name, sum);
      end
    end
  endtask

  task automatic test_impulse();
    clk_enable = 1'b1;
    main_reset();
    got.delete();
    main_cycle(1'b1, 12'sd1);
    for (int i = 0; i < 40; i++) main_cycle(1'b1, 12'sd0);
    check_impulse_table("impulse");
  endtask

  task automatic test_dc();
    for (int v = 0; v < 2; v++) begin
      logic signed [11:0] x = (v == 0) ? 12'sd1 : -12'sd2048;
      longint want = (v == 0) ? 100 : -204800;
      clk_enable = 1'b1;
      main_reset();
      for (int i = 0; i < 200; i++) main_cycle(1'b1, x);
      for (int i = 0; i < 10; i++) begin
        main_cycle(1'b1, x);
        checks++;
        if (longint'($signed(filter_out)) !== want) begin
          errors++; $display("FAIL dc_level: got %0d expected %0d", $signed(filter_out), want);
        end
      end
    end
  endtask

  task automatic test_enable_toggle();
    clk_enable = 1'b1;
    main_reset();
    got.delete();
    for (int i = 0; i < 92; i++)
      main_cycle((i % 2) == 0, (i == 0) ? 12'sd1 : 12'sd0);
    check_impulse_table("toggle");
  endtask

  task automatic test_reset_mid();
    clk_enable = 1'b1;
    main_reset();
    main_cycle(1'b1, 12'sd1);
    for (int i = 0; i < 6; i++) main_cycle(1'b1, 12'sd0);
    main_reset();
    for (int i = 0; i < 40; i++) main_cycle(1'b1, 12'sd0);
  endtask

  task automatic test_random_r2();
    int     xq[$];
    longint eq[$];
    int     cnt = 0;
    int     samples = 0;
    longint e = 0;
    longint s;
    logic   en;
    logic   exp_strobe;
    logic signed [11:0] x;
    clk_enable2 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    eq = '{0, 0, 0, 0};
    for (int cyc = 0; cyc < 2600 && samples < 1000; cyc++) begin
      en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       x = 12'sd2047;
        1:       x = -12'sd2048;
        default: x = 12'($urandom);
      endcase
      clk_enable2 = en;
      filter_in2  = x;
      #1;
      exp_strobe = en && (cnt == 0);
      checks++;
      if (in_strobe2 !== exp_strobe) begin
        errors++; $display("FAIL r2_strobe: got %b expected %b", in_strobe2, exp_strobe);
      end
      @(posedge clk); #1;
      if (en) begin
        xq.push_back((cnt == 0) ? int'(x) : 0);
        if (cnt == 0) samples++;
        cnt = (cnt == 1) ? 0 : 1;
        s = 0;
        for (int k = 0; k <= 3; k++)
          if (xq.size() - 1 - k >= 0) s += longint'(h_coef(2, k)) * longint'(xq[xq.size() - 1 - k]);
        eq.push_back(wrap(s, 14));
        e = eq.pop_front();
      end
      checks++;
      if (longint'($signed(filter_out2)) !== e) begin
        errors++; $display("FAIL r2_out: got %0d expected %0d", $signed(filter_out2), e);
      end
    end
    clk_enable2 = 1'b0;
    checks++;
    if (samples < 1000) begin
      errors++; $display("FAIL r2_samples: got %0d expected 1000", samples);
    end
  endtask

  task automatic test_wrap_w15();
    for (int v = 0; v < 2; v++) begin
      logic signed [11:0] x = (v == 0) ? 12'sd2047 : -12'sd2048;
      longint want = (v == 0) ? 8188 : -8192;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clk_enable3 = 1'b1;
      filter_in3  = x;
      for (int i = 0; i < 20; i++) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        checks++;
        if (longint'($signed(filter_out3)) !== want) begin
          errors++; $display("FAIL w15_dc: got %0d expected %0d", $signed(filter_out3), want);
        end
      end
      checks++;
      if (ce_out3 !== 1'b1) begin
        errors++; $display("FAIL w15_ce: got %b expected 1", ce_out3);
      end
      checks++;
      if (in_strobe3 !== 1'b0 && in_strobe3 !== 1'b1) begin
        errors++; $display("FAIL w15_strobe: got %b expected 0 or 1", in_strobe3);
      end
      clk_enable3 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_enable_toggle();
    test_reset_mid();
    test_random_r2();
    test_wrap_w15();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
